// File: rtl/ahbl_splitter_n.sv
// rtl/ahbl_splitter_n.sv - AHB-Lite 1:NS address splitter with built-in error default slave
module ahbl_splitter_n #(
    parameter int NS = 4,
    parameter int DEC_W = 4,
    parameter logic [NS*DEC_W-1:0] BASES = {4'h8, 4'h4, 4'h2, 4'h0}
) (
    input  logic             HCLK,
    input  logic             HRESET,
    input  logic [31:0]      HADDR,
    input  logic [1:0]       HTRANS,
    output logic             HREADY,
    output logic [31:0]      HRDATA,
    output logic             HRESP,
    output logic [NS-1:0]    S_HSEL,
    input  logic [NS*32-1:0] S_HRDATA,
    input  logic [NS-1:0]    S_HREADYOUT,
    input  logic [NS-1:0]    S_HRESP,
    input  logic             ERR_CLR,
    output logic             ERR_FLAG,
    output logic [31:0]      ERR_ADDR,
    output logic [7:0]       ERR_CNT
);

    localparam int IW = (NS > 1) ? $clog2(NS) : 1;

    typedef enum logic [1:0] {SEL_NONE, SEL_SLAVE, SEL_DFLT} sel_t;
    typedef enum logic [1:0] {ST_IDLE, ST_ERR1, ST_ERR2} err_state_t;

    sel_t        sel_kind;
    logic [IW-1:0] sel_idx;
    err_state_t  err_state;
    logic        fsm_hready;
    logic        fsm_hresp;

    logic          hit;
    logic [IW-1:0] hit_idx;
    logic          dflt;
    logic          err_entry;
    logic          unused_htrans0;

    assign unused_htrans0 = HTRANS[0];

    // Scan from the top so the lowest matching slot is the one left standing.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = NS - 1; i >= 0; i--) begin
            if (HADDR[31 -: DEC_W] == BASES[i*DEC_W +: DEC_W]) begin
                hit     = 1'b1;
                hit_idx = IW'(i);
            end
        end
        S_HSEL = hit ? (NS'(1) << hit_idx) : '0;
    end

    assign dflt      = HTRANS[1] & ~hit;
    assign err_entry = dflt & HREADY;

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            sel_kind <= SEL_NONE;
            sel_idx  <= '0;
        end else if (HREADY) begin
            if (HTRANS[1] && hit) begin
                sel_kind <= SEL_SLAVE;
                sel_idx  <= hit_idx;
            end else if (dflt) begin
                sel_kind <= SEL_DFLT;
            end else begin
                sel_kind <= SEL_NONE;
            end
        end
    end

    // Default slave: ERR1 stalls with ERROR, ERR2 completes it; capture happens on ERR1 entry.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            err_state  <= ST_IDLE;
            fsm_hready <= 1'b1;
            fsm_hresp  <= 1'b0;
            ERR_FLAG   <= 1'b0;
            ERR_ADDR   <= '0;
            ERR_CNT    <= '0;
        end else begin
            case (err_state)
                ST_IDLE: begin
                    if (err_entry) begin
                        err_state  <= ST_ERR1;
                        fsm_hready <= 1'b0;
                        fsm_hresp  <= 1'b1;
                    end
                end
                ST_ERR1: begin
                    err_state  <= ST_ERR2;
                    fsm_hready <= 1'b1;
                    fsm_hresp  <= 1'b1;
                end
                ST_ERR2: begin
                    if (dflt) begin
                        err_state  <= ST_ERR1;
                        fsm_hready <= 1'b0;
                        fsm_hresp  <= 1'b1;
                    end else begin
                        err_state  <= ST_IDLE;
                        fsm_hready <= 1'b1;
                        fsm_hresp  <= 1'b0;
                    end
                end
                default: begin
                    err_state  <= ST_IDLE;
                    fsm_hready <= 1'b1;
                    fsm_hresp  <= 1'b0;
                end
            endcase

            if (err_entry) begin
                ERR_ADDR <= HADDR;
                ERR_FLAG <= 1'b1;
                if (ERR_CLR)
                    ERR_CNT <= 8'd1;
                else if (ERR_CNT != 8'hFF)
                    ERR_CNT <= ERR_CNT + 8'd1;
            end else if (ERR_CLR) begin
                ERR_FLAG <= 1'b0;
                ERR_CNT  <= '0;
            end
        end
    end

    always_comb begin
        HREADY = 1'b1;
        HRESP  = 1'b0;
        HRDATA = '0;
        case (sel_kind)
            SEL_SLAVE: begin
                for (int i = 0; i < NS; i++) begin
                    if (sel_idx == IW'(i)) begin
                        HREADY = S_HREADYOUT[i];
                        HRESP  = S_HRESP[i];
                        HRDATA = S_HRDATA[i*32 +: 32];
                    end
                end
            end
            SEL_DFLT: begin
                HREADY = fsm_hready;
                HRESP  = fsm_hresp;
            end
            default: ;
        endcase
    end

endmodule
